// File: rtl/mem_init_gen.sv
// Memory initialiser: fills DEPTH RAM words with a selectable pattern, then
// optionally reads every word back and records mismatches.
module mem_init_gen #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill,
  input  logic              verify,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  input  logic [DATA_W-1:0] rddata,
  output logic              err,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  generate
    if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("mem_init_gen: DEPTH must be in 2..2**ADDR_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_RD_ISSUE = 2'd2,
    S_RD_CMP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_idx;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_fill;
  logic                r_verify;
  logic                r_rdy;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wrdata;
  logic                r_wren;
  logic                r_err;
  logic [CNT_W-1:0]    r_err_count;
  logic [ADDR_W-1:0]   r_err_addr;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_idx_nxt;
  logic                w_start;
  logic                w_cmp;
  logic                w_mismatch;
  logic [1:0]          w_mode_eff;
  logic [DATA_W-1:0]   w_fill_eff;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_wrdata_nxt;
  logic                w_wren_nxt;
  logic                w_rdy_nxt;

  function automatic logic [DATA_W-1:0] pattern_f(
    input logic [CNT_W-1:0]  idx,
    input logic [1:0]        m,
    input logic [DATA_W-1:0] f
  );
    logic [DATA_W-1:0] v;
    v = DATA_W'(idx);
    case (m)
      2'b00:   pattern_f = v;
      2'b01:   pattern_f = f;
      2'b10:   pattern_f = DATA_W'(LAST_IDX - idx);
      default: pattern_f = v ^ f;
    endcase
  endfunction

  // Next state, next index and the registered-output next values
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_start      = 1'b0;
    w_cmp        = 1'b0;
    w_mode_eff   = r_mode;
    w_fill_eff   = r_fill;
    w_addr_nxt   = '0;
    w_wrdata_nxt = '0;
    w_wren_nxt   = 1'b0;
    w_rdy_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_start     = 1'b1;
          w_state_nxt = S_WRITE;
          w_idx_nxt   = '0;
        end
      end
      S_WRITE: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = r_verify ? S_RD_ISSUE : S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + CNT_W'(1);
        end
      end
      S_RD_ISSUE: begin
        w_state_nxt = S_RD_CMP;
      end
      S_RD_CMP: begin
        w_cmp = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = S_RD_ISSUE;
          w_idx_nxt   = r_idx + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    // First write pattern must use the operands being latched this edge
    if (w_start) begin
      w_mode_eff = mode;
      w_fill_eff = fill;
    end

    w_rdy_nxt = (w_state_nxt == S_IDLE);
    if (w_state_nxt != S_IDLE) begin
      w_addr_nxt = ADDR_W'(w_idx_nxt);
    end
    if (w_state_nxt == S_WRITE) begin
      w_wren_nxt   = 1'b1;
      w_wrdata_nxt = pattern_f(w_idx_nxt, w_mode_eff, w_fill_eff);
    end
  end

  assign w_mismatch = w_cmp && (rddata != pattern_f(r_idx, r_mode, r_fill));

  // State, index, latched operands and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_mode      <= '0;
      r_fill      <= '0;
      r_verify    <= 1'b0;
      r_rdy       <= 1'b1;
      r_addr      <= '0;
      r_wrdata    <= '0;
      r_wren      <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_rdy    <= w_rdy_nxt;
      r_addr   <= w_addr_nxt;
      r_wrdata <= w_wrdata_nxt;
      r_wren   <= w_wren_nxt;
      if (w_start) begin
        r_mode      <= mode;
        r_fill      <= fill;
        r_verify    <= verify;
        r_err       <= 1'b0;
        r_err_count <= '0;
        r_err_addr  <= '0;
      end else if (w_mismatch) begin
        r_err <= 1'b1;
        if (r_err_count != DEPTH_C) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
        if (!r_err) begin
          r_err_addr <= ADDR_W'(r_idx);
        end
      end
    end
  end

  assign rdy       = r_rdy;
  assign addr      = r_addr;
  assign wrdata    = r_wrdata;
  assign wren      = r_wren;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign err_addr  = r_err_addr;

endmodule

// File: doc/mem_init_gen.md
Name: mem_init_gen

Overview:
Parameterised memory initialiser, the next generation of the single-pattern S-array init block. It fills DEPTH words of an external synchronous RAM with one of four selectable patterns, then optionally reads every word back and checks it. It sits between the top-level controller (en/rdy handshake) and the RAM port in the crypto datapath.

Parameters:
ADDR_W, 8, RAM address width.
DATA_W, 8, RAM data width.
DEPTH, 256, number of words initialised; legal range 2 to 2**ADDR_W, otherwise elaboration error.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  start request; sampled only while rdy=1.
rdy  output  1  high when idle and able to accept en.
mode  input  2  pattern select; latched at start.
fill  input  DATA_W  pattern operand; latched at start.
verify  input  1  enables the read-back pass; latched at start.
addr  output  ADDR_W  RAM address.
wrdata  output  DATA_W  RAM write data.
wren  output  1  RAM write enable.
rddata  input  DATA_W  RAM read data; valid one cycle after addr is presented with wren=0.
err  output  1  a verify mismatch occurred in the last run.
err_count  output  ADDR_W+1  number of mismatching words, saturating at DEPTH.
err_addr  output  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset (asynchronous, immediate): rdy=1, wren=0, addr=0, wrdata=0, err=0, err_count=0, err_addr=0, state=IDLE. A reset mid-run aborts the run with no further writes.
- Pattern for index i, with v = i zero-extended or truncated to DATA_W:
  - mode 00: identity, v.
  - mode 01: constant, fill.
  - mode 10: reverse, (DEPTH-1-i) resized to DATA_W.
  - mode 11: xor, v ^ fill.
- States: IDLE, WRITE, RD_ISSUE, RD_CMP.
- IDLE:
  - Outputs addr=0, wrdata=0, wren=0, rdy=1.
  - On an edge with en=1: latch mode, fill and verify; clear err, err_count and err_addr; set i=0; go to WRITE. rdy goes low in the following cycle.
- WRITE: one word per cycle.
  - Outputs wren=1, addr=i, wrdata=pattern(i).
  - If i=DEPTH-1, go to RD_ISSUE with i=0 when verify=1, else go to IDLE. Otherwise i++.
  - This gives exactly DEPTH consecutive write cycles.
- RD_ISSUE:
  - Outputs wren=0, addr=i, wrdata=0.
  - Go to RD_CMP.
- RD_CMP:
  - Hold addr=i, wren=0.
  - Compare rddata with pattern(i). On mismatch: err=1 and err_count++ (saturating). err_addr is set only on the first mismatch.
  - If i=DEPTH-1, go to IDLE; else i++ and go to RD_ISSUE.
- rdy low duration: DEPTH cycles without verify, 3*DEPTH cycles with verify.
- rdy returns high in the cycle after the last WRITE or RD_CMP cycle. en may be asserted in that same cycle to start back-to-back.
- en while rdy=0 is ignored; it is not queued.
- Changes to mode, fill or verify during a run have no effect.
- err, err_count and err_addr hold their values while in IDLE until the next start.
- Index counter is ADDR_W+1 bits internally so the DEPTH=2**ADDR_W terminal compare does not wrap.
- wren is never asserted outside WRITE.

Test Plan:
- Default params, mode=00, verify=0, en pulsed 1 cycle → rdy low exactly 256 cycles. Writes addr 0..255 with wrdata=addr, wren=1 each cycle, then rdy=1, wren=0, addr=0.
- mode=01, fill=0xA5, verify=1, behavioural RAM model → 256 writes of 0xA5, then 512 verify cycles; rdy low 768 cycles. Final err=0, err_count=0, err_addr=0.
- mode=11, fill=0x0F, verify=1, RAM model forces word 0x37 to 0x00 and word 0x80 to 0xFF → err=1, err_count=2, err_addr=0x37.
- DEPTH=16, ADDR_W=4, DATA_W=8, mode=10 → writes 15,14,...,0 to addr 0..15; rdy low 16 cycles. A second en in the cycle rdy rises restarts immediately.
- en held high throughout, with mode toggled mid-run → single run using the latched mode, no restart until rdy=1. rst_n pulsed low at write 100 → wren=0 and rdy=1 immediately, err_count=0, and a subsequent en runs from addr 0.
